// File: rtl/accel_pkg.sv
// accel_pkg: shared states, opcodes, bus IDs and command-word layout for accel_cmd_fsm
package accel_pkg;

    localparam int ID_W = 2;

    localparam logic [ID_W-1:0] MEM_ID = 2'b00;

    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b10;
    localparam logic [1:0] OP_EXEC = 2'b11;

    // Bit offsets of the low command fields; the address sits above F_ADDR
    localparam int F_OPC  = 0;
    localparam int F_SRC  = 2;
    localparam int F_DST  = 4;
    localparam int F_RSV  = 6;
    localparam int F_MODE = 7;
    localparam int F_ADDR = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_OP_REQ,
        S_OP_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_DONE
    } state_t;

    // Builds the address-independent low byte of a bus command
    function automatic logic [F_ADDR-1:0] cmd_fields(
        input logic            mode,
        input logic [ID_W-1:0] dst,
        input logic [ID_W-1:0] src,
        input logic [1:0]      opc
    );
        logic [F_ADDR-1:0] f;
        f              = '0;
        f[F_OPC +: 2]  = opc;
        f[F_SRC +: 2]  = src;
        f[F_DST +: 2]  = dst;
        f[F_RSV]       = 1'b0;
        f[F_MODE]      = mode;
        return f;
    endfunction

endpackage

// File: rtl/ack_watchdog.sv
// ack_watchdog: counts enabled cycles and flags the cycle in which the count reaches all-ones
module ack_watchdog #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic expire
);

    logic [W-1:0] cnt;

    // Count while enabled; any gap in enable restarts from zero
    always_ff @(posedge clk) begin
        cnt <= (rst || !en) ? '0 : cnt + 1'b1;
    end

    assign expire = en && (&(cnt + W'(1)));

endmodule

// File: rtl/accel_cmd_fsm.sv
// accel_cmd_fsm: per-request read/op/write command sequencer; CMD_TIMEOUT_EN adds an ack watchdog
module accel_cmd_fsm
    import accel_pkg::*;
#(
    parameter int          ADDRW     = 24,
    parameter logic [1:0]  ACCEL_ID  = 2'b01,
    parameter int          NUM_SRC   = 2,
    parameter int          TIMEOUT_W = 8,
    localparam int         SW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int         REQW      = 1 + SW + (NUM_SRC + 1) * ADDRW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [REQW-1:0]   req_data,
    output logic              ready_req_out,
    output logic              arb_req,
    input  logic              arb_grant,
    input  logic [2:0]        ack_in,
    output logic [ADDRW+7:0]  data_out,
    input  logic              comq_ready_in,
    output logic              valid_compq_out,
    output logic [ADDRW-1:0]  compq_data_out,
    output logic              compq_err_out
);

    localparam logic [SW:0] NSRC_MAX = (SW + 1)'(NUM_SRC - 1);

    state_t                   state;
    logic [ADDRW-1:0]         dest;
    logic [NUM_SRC*ADDRW-1:0] srcs;
    logic [SW-1:0]            nsrc;
    logic [SW-1:0]            idx;
    logic                     mode;
    logic                     err;
    logic                     wd_expire;

    logic [SW-1:0] nsrc_in;
    logic [SW-1:0] nsrc_cap;
    logic          ack_mem;
    logic          ack_acc;

    assign nsrc_in  = req_data[(NUM_SRC+1)*ADDRW +: SW];
    assign nsrc_cap = ({1'b0, nsrc_in} > NSRC_MAX) ? NSRC_MAX[SW-1:0] : nsrc_in;
    assign ack_mem  = ack_in == {1'b1, MEM_ID};
    assign ack_acc  = ack_in == {1'b1, ACCEL_ID};

`ifdef CMD_TIMEOUT_EN
    logic wd_en;

    assign wd_en = ((state == S_RD_WAIT || state == S_WR_WAIT) && !ack_mem) ||
                   (state == S_OP_WAIT && !ack_acc);

    ack_watchdog #(.W(TIMEOUT_W)) u_wd (
        .clk    (clk),
        .rst    (rst),
        .en     (wd_en),
        .expire (wd_expire)
    );
`else
    // Without the watchdog a wait never expires; TIMEOUT_W stays so both builds share one parameter list
    assign wd_expire = (TIMEOUT_W == 0);
`endif

    // Sequencer: accept, read each source, issue the op, write back, post completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            dest  <= '0;
            srcs  <= '0;
            nsrc  <= '0;
            idx   <= '0;
            mode  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    dest  <= req_data[ADDRW-1:0];
                    srcs  <= req_data[ADDRW +: NUM_SRC*ADDRW];
                    nsrc  <= nsrc_cap;
                    mode  <= req_data[REQW-1];
                    idx   <= '0;
                    err   <= 1'b0;
                    state <= S_RD_REQ;
                end
                S_RD_REQ: if (arb_grant) state <= S_RD_WAIT;
                S_RD_WAIT: if (ack_mem) begin
                    if (idx != nsrc) idx <= idx + 1'b1;
                    state <= (idx == nsrc) ? S_OP_REQ : S_RD_REQ;
                end else if (wd_expire) begin
                    err   <= 1'b1;
                    state <= S_DONE;
                end
                S_OP_REQ: if (arb_grant) state <= S_OP_WAIT;
                S_OP_WAIT: if (ack_acc) begin
                    state <= S_WR_REQ;
                end else if (wd_expire) begin
                    err   <= 1'b1;
                    state <= S_DONE;
                end
                S_WR_REQ: if (arb_grant) state <= S_WR_WAIT;
                S_WR_WAIT: if (ack_mem) begin
                    state <= S_DONE;
                end else if (wd_expire) begin
                    err   <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: if (comq_ready_in) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [ADDRW+7:0] rd_cmd;
    logic [ADDRW+7:0] op_cmd;
    logic [ADDRW+7:0] wr_cmd;
    logic             in_rd;
    logic             in_op;
    logic             in_wr;

    assign rd_cmd = {srcs[int'(idx)*ADDRW +: ADDRW], cmd_fields(1'b0, ACCEL_ID, MEM_ID, OP_RD)};
    assign op_cmd = {{ADDRW{1'b0}}, cmd_fields(mode, ACCEL_ID, ACCEL_ID, OP_EXEC)};
    assign wr_cmd = {dest, cmd_fields(1'b0, MEM_ID, ACCEL_ID, OP_WR)};

    assign in_rd = state == S_RD_REQ || state == S_RD_WAIT;
    assign in_op = state == S_OP_REQ || state == S_OP_WAIT;
    assign in_wr = state == S_WR_REQ || state == S_WR_WAIT;

    // Output decode straight from state and captured request
    always_comb begin
        ready_req_out   = state == S_IDLE;
        arb_req         = state == S_RD_REQ || state == S_OP_REQ || state == S_WR_REQ;
        data_out        = in_rd ? rd_cmd : in_op ? op_cmd : in_wr ? wr_cmd : '0;
        valid_compq_out = state == S_DONE;
        compq_data_out  = (state == S_DONE) ? dest : '0;
        compq_err_out   = (state == S_DONE) && err;
    end

endmodule

// File: tb/tb_accel_cmd_fsm.sv
// tb_accel_cmd_fsm: scoreboard bench driving requests, grants and acks into accel_cmd_fsm
module tb_accel_cmd_fsm;

    localparam int         ADDRW = 24;
    localparam int         NSRC  = 2;
    localparam int         TW    = 4;
    localparam logic [1:0] AID   = 2'b01;
    localparam int         REQW  = 1 + 1 + (NSRC + 1) * ADDRW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic [REQW-1:0]   req_data = '0;
    logic              ready_req_out;
    logic              arb_req;
    logic              arb_grant = 1'b0;
    logic [2:0]        ack_in = '0;
    logic [ADDRW+7:0]  data_out;
    logic              comq_ready_in = 1'b0;
    logic              valid_compq_out;
    logic [ADDRW-1:0]  compq_data_out;
    logic              compq_err_out;

    accel_cmd_fsm #(
        .ADDRW     (ADDRW),
        .ACCEL_ID  (AID),
        .NUM_SRC   (NSRC),
        .TIMEOUT_W (TW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .ready_req_out   (ready_req_out),
        .arb_req         (arb_req),
        .arb_grant       (arb_grant),
        .ack_in          (ack_in),
        .data_out        (data_out),
        .comq_ready_in   (comq_ready_in),
        .valid_compq_out (valid_compq_out),
        .compq_data_out  (compq_data_out),
        .compq_err_out   (compq_err_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] cmd_q[$];
    logic [24:0] comp_q[$];
    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] mk(input logic [23:0] a, input logic m,
                                       input logic [1:0] d, input logic [1:0] s,
                                       input logic [1:0] o);
        return {a, m, 1'b0, d, s, o};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (ready_req_out !== 1'b1 || arb_req !== 1'b0 || data_out !== '0 ||
            valid_compq_out !== 1'b0 || compq_data_out !== '0 || compq_err_out !== 1'b0) begin
            errors++;
            $display("FAIL %s: ready=%b arb=%b data=%h valid=%b cdata=%h err=%b, required 1 0 0 0 0 0",
                     name, ready_req_out, arb_req, data_out, valid_compq_out, compq_data_out, compq_err_out);
        end
    endtask

    task automatic send_req(input logic n, input logic [23:0] s0, input logic [23:0] s1,
                            input logic [23:0] dst, input logic m, input bit push);
        if (push) begin
            cmd_q.push_back(mk(s0, 1'b0, AID, 2'b00, 2'b01));
            if (n) cmd_q.push_back(mk(s1, 1'b0, AID, 2'b00, 2'b01));
            cmd_q.push_back(mk(24'h0, m, AID, AID, 2'b11));
            cmd_q.push_back(mk(dst, 1'b0, 2'b00, AID, 2'b10));
            comp_q.push_back({1'b0, dst});
        end
        checks++;
        if (ready_req_out !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: ready_req_out=%b required 1", ready_req_out);
        end
        req_data  = {m, n, s1, s0, dst};
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
    endtask

    task automatic serve(input int gd, input bit wrong, output int lat);
        int budget = 300;
        int start  = cyc;
        while (valid_compq_out !== 1'b1 && budget > 0) begin
            if (arb_req === 1'b1) begin
                logic [31:0] held;
                logic [31:0] exp;
                held = data_out;
                exp  = 'x;
                for (int i = 0; i < gd; i++) begin
                    ack_in = (wrong && i == 0) ? 3'b100 : 3'b000;
                    tick;
                    ack_in = 3'b000;
                    checks++;
                    if (arb_req !== 1'b1 || data_out !== held) begin
                        errors++;
                        $display("FAIL stall_hold: arb_req=%b data_out=%h required 1 and %h", arb_req, data_out, held);
                    end
                end
                if (cmd_q.size() > 0) exp = cmd_q.pop_front();
                checks++;
                if (data_out !== exp) begin
                    errors++;
                    $display("FAIL cmd: data_out=%h required %h", data_out, exp);
                end
                arb_grant = 1'b1;
                tick;
                arb_grant = 1'b0;
                checks++;
                if (arb_req !== 1'b0 || data_out !== held) begin
                    errors++;
                    $display("FAIL wait_hold: arb_req=%b data_out=%h required 0 and %h", arb_req, data_out, held);
                end
                if (wrong && exp[1:0] == 2'b01) begin
                    ack_in = 3'b101;
                    tick;
                    ack_in = 3'b000;
                    checks++;
                    if (arb_req !== 1'b0 || data_out !== held || valid_compq_out !== 1'b0) begin
                        errors++;
                        $display("FAIL wrong_ack: arb_req=%b data_out=%h valid=%b required 0, %h, 0",
                                 arb_req, data_out, valid_compq_out, held);
                    end
                end
                ack_in = {1'b1, (exp[1:0] == 2'b11) ? AID : 2'b00};
                tick;
                ack_in = 3'b000;
            end else begin
                tick;
            end
            budget--;
        end
        lat = cyc - start + 1;
        checks++;
        if (valid_compq_out !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: valid_compq_out=%b required 1", valid_compq_out);
        end
        checks++;
        if (cmd_q.size() != 0) begin
            errors++;
            $display("FAIL cmd_count: %0d commands still expected, required 0", cmd_q.size());
            cmd_q.delete();
        end
    endtask

    task automatic finish_done(input int hold);
        logic [24:0] e;
        e = 'x;
        if (comp_q.size() > 0) e = comp_q.pop_front();
        for (int i = 0; i <= hold; i++) begin
            checks++;
            if (valid_compq_out !== 1'b1 || ready_req_out !== 1'b0 ||
                compq_data_out !== e[23:0] || compq_err_out !== e[24]) begin
                errors++;
                $display("FAIL done_out: valid=%b ready=%b data=%h err=%b required 1 0 %h %b",
                         valid_compq_out, ready_req_out, compq_data_out, compq_err_out, e[23:0], e[24]);
            end
            if (i < hold) tick;
        end
        comq_ready_in = 1'b1;
        tick;
        comq_ready_in = 1'b0;
        check_idle_outputs("return_idle");
    endtask

    task automatic to_op_wait(input logic m);
        send_req(1'b0, 24'h000A00, 24'h000B00, 24'h000C00, m, 1'b0);
        arb_grant = 1'b1;
        tick;
        arb_grant = 1'b0;
        ack_in = 3'b100;
        tick;
        ack_in = 3'b000;
        arb_grant = 1'b1;
        tick;
        arb_grant = 1'b0;
        checks++;
        if (arb_req !== 1'b0 || data_out !== {8'h0, mk(24'h0, m, AID, AID, 2'b11)}) begin
            errors++;
            $display("FAIL op_wait_entry: arb_req=%b data_out=%h required 0 and %h",
                     arb_req, data_out, mk(24'h0, m, AID, AID, 2'b11));
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        check_idle_outputs("reset");
        rst = 1'b0;
        tick;
        check_idle_outputs("post_reset");
    endtask

    task automatic test_basic;
        int lat;
        send_req(1'b1, 24'h000100, 24'h000200, 24'h000300, 1'b1, 1'b1);
        serve(0, 1'b0, lat);
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL latency_two_src: %0d cycles, required 9", lat);
        end
        finish_done(0);
    endtask

    task automatic test_single_src;
        int lat;
        send_req(1'b0, 24'h0ABCDE, 24'h0FFFFF, 24'h123456, 1'b0, 1'b1);
        serve(0, 1'b0, lat);
        checks++;
        if (lat != 7) begin
            errors++;
            $display("FAIL latency_one_src: %0d cycles, required 7", lat);
        end
        finish_done(0);
    endtask

    task automatic test_stall_wrong_ack;
        int lat;
        send_req(1'b1, 24'h111111, 24'h222222, 24'h333333, 1'b1, 1'b1);
        serve(10, 1'b1, lat);
        finish_done(5);
    endtask

    task automatic test_reset_mid;
        int lat;
        to_op_wait(1'b1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_idle_outputs("reset_mid");
        send_req(1'b1, 24'h000400, 24'h000500, 24'h000600, 1'b0, 1'b1);
        serve(0, 1'b0, lat);
        finish_done(0);
    endtask

    task automatic test_back_to_back;
        int lat;
        for (int k = 0; k < 4; k++) begin
            logic n;
            n = 1'($urandom_range(0, 1));
            send_req(n, 24'($urandom), 24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            serve(k, k[0], lat);
            finish_done(k);
        end
    endtask

`ifdef CMD_TIMEOUT_EN
    task automatic test_timeout;
        to_op_wait(1'b0);
        repeat (14) tick;
        checks++;
        if (valid_compq_out !== 1'b0 || data_out !== {8'h0, mk(24'h0, 1'b0, AID, AID, 2'b11)}) begin
            errors++;
            $display("FAIL timeout_early: valid=%b data_out=%h required 0 and op command", valid_compq_out, data_out);
        end
        tick;
        comp_q.push_back({1'b1, 24'h000C00});
        ack_in = {1'b1, AID};
        tick;
        ack_in = 3'b000;
        checks++;
        if (arb_req !== 1'b0 || data_out !== '0) begin
            errors++;
            $display("FAIL timeout_no_write: arb_req=%b data_out=%h required 0 0", arb_req, data_out);
        end
        finish_done(1);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset;
        test_basic;
        test_single_src;
        test_stall_wrong_ack;
        test_reset_mid;
        test_back_to_back;
`ifdef CMD_TIMEOUT_EN
        test_timeout;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
